// File: rtl/avalon_ram_agent.sv
// avalon_ram_agent: Avalon-MM agent with a word-organised RAM behind it.
// Serves one transfer at a time. It inserts WAIT_STATES stall cycles, then
// gives a single response cycle in which waitrequest is low and, for reads,
// readdatavalid is high.
// Optional build macro: AVALON_RAM_AGENT_ERR_EN adds a sticky err output that
// flags out-of-range addresses, unsupported byteenable patterns and
// simultaneous read+write requests. An erroring write is not committed.
module avalon_ram_agent #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] host_to_agent,
    output logic [31:0] agent_to_host,
    output logic        waitrequest,
    output logic        readdatavalid
`ifdef AVALON_RAM_AGENT_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int AW    = $clog2(DEPTH);
    // When WAIT_STATES is 0 the counter is never loaded. It still needs a
    // legal width of at least one bit.
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic            op_read_reg, op_read_next;
    logic [AW-1:0]   idx_reg,     idx_next;
    logic [3:0]      be_reg,      be_next;
    logic [31:0]     wdata_reg,   wdata_next;
    logic [31:0]     rdata_reg;

    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   req_idx;
    logic            commit_ok;
    logic            commit_we;
    logic            load_en;
    logic [3:0]      lane_we;

    // Word index only. The byte offset and the upper address bits do not
    // select storage.
    assign req_idx = address[AW+1:2];

`ifdef AVALON_RAM_AGENT_ERR_EN
    logic err_lat_reg, err_lat_next;
    logic err_reg;
    logic req_err;

    // Classify the request as it is accepted. The result is applied in RESP.
    assign req_err = (read && write)
                   || ((address >> (AW + 2)) != 32'd0)
                   || !((byteenable == 4'b0001) || (byteenable == 4'b0011)
                        || (byteenable == 4'b1111));

    assign commit_ok = !err_lat_reg;
    // Visible in the RESP cycle itself, then held by the sticky register.
    assign err       = err_reg || ((state_reg == RESP) && err_lat_reg);

    // Sticky error flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg     <= 1'b0;
            err_lat_reg <= 1'b0;
        end else begin
            err_lat_reg <= err_lat_next;
            if ((state_reg == RESP) && err_lat_reg) begin
                err_reg <= 1'b1;
            end
        end
    end
`else
    assign commit_ok = 1'b1;
`endif

    // Address bits that never select storage in this configuration.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[1:0], address[31:AW+2]};

    // Next-state logic. It also captures the request in IDLE.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        op_read_next = op_read_reg;
        idx_next     = idx_reg;
        be_next      = be_reg;
        wdata_next   = wdata_reg;
`ifdef AVALON_RAM_AGENT_ERR_EN
        err_lat_next = err_lat_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (read || write) begin
                    // Read wins when both strobes are high. The write data is then unused.
                    op_read_next = read;
                    idx_next     = req_idx;
                    be_next      = byteenable;
                    wdata_next   = host_to_agent;
`ifdef AVALON_RAM_AGENT_ERR_EN
                    err_lat_next = req_err;
`endif
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (!read && !write) begin
                    // The host withdrew the request. Drop it with no side effects.
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and request capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            op_read_reg <= 1'b0;
            idx_reg     <= '0;
            be_reg      <= '0;
            wdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            op_read_reg <= op_read_next;
            idx_reg     <= idx_next;
            be_reg      <= be_next;
            wdata_reg   <= wdata_next;
        end
    end

    // A write commits at the end of its RESP cycle. A reset in that cycle
    // cancels the commit.
    assign commit_we = (state_reg == RESP) && !op_read_reg && commit_ok && !rst;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = commit_we && be_reg[gi];
        end
    endgenerate

    // Byte-lane RAM write port.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[idx_reg][8*i +: 8] <= wdata_reg[8*i +: 8];
            end
        end
    end

    // Registered read. It loads on entry to RESP for a read and otherwise holds the last word.
    assign load_en = (state_next == RESP) && op_read_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (load_en) begin
            rdata_reg <= mem[idx_next];
        end
    end

    assign agent_to_host = rdata_reg;
    assign waitrequest   = (state_reg != RESP);
    assign readdatavalid = (state_reg == RESP) && op_read_reg;

endmodule

// File: tb/tb_avalon_ram_agent.sv
// Directed bench for avalon_ram_agent. Three instances share the clock and
// reset: WAIT_STATES = 1, 0 and 3 (index 0, 1, 2).
module tb_avalon_ram_agent;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address       [3];
    logic        read          [3];
    logic        write         [3];
    logic [3:0]  byteenable    [3];
    logic [31:0] host_to_agent [3];
    logic [31:0] agent_to_host [3];
    logic        waitrequest   [3];
    logic        readdatavalid [3];
`ifdef AVALON_RAM_AGENT_ERR_EN
    logic        err           [3];
`endif

    int n_vec  = 0;
    int n_miss = 0;
    logic resp_err;

    always #5 clk = ~clk;

    avalon_ram_agent #(.DEPTH(1024), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .address(address[0]), .read(read[0]), .write(write[0]),
        .byteenable(byteenable[0]), .host_to_agent(host_to_agent[0]),
        .agent_to_host(agent_to_host[0]), .waitrequest(waitrequest[0]),
        .readdatavalid(readdatavalid[0])
`ifdef AVALON_RAM_AGENT_ERR_EN
        , .err(err[0])
`endif
    );

    avalon_ram_agent #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .address(address[1]), .read(read[1]), .write(write[1]),
        .byteenable(byteenable[1]), .host_to_agent(host_to_agent[1]),
        .agent_to_host(agent_to_host[1]), .waitrequest(waitrequest[1]),
        .readdatavalid(readdatavalid[1])
`ifdef AVALON_RAM_AGENT_ERR_EN
        , .err(err[1])
`endif
    );

    avalon_ram_agent #(.DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .address(address[2]), .read(read[2]), .write(write[2]),
        .byteenable(byteenable[2]), .host_to_agent(host_to_agent[2]),
        .agent_to_host(agent_to_host[2]), .waitrequest(waitrequest[2]),
        .readdatavalid(readdatavalid[2])
`ifdef AVALON_RAM_AGENT_ERR_EN
        , .err(err[2])
`endif
    );

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transfer: present at negedge, count cycles until waitrequest drops.
    task automatic xfer(input int k, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic rdv, output int lat);
        @(negedge clk);
        address[k]       = a;
        byteenable[k]    = be;
        host_to_agent[k] = wd;
        read[k]          = rd;
        write[k]         = wr;
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (waitrequest[k] && lat < 20);
        rdata = agent_to_host[k];
        rdv   = readdatavalid[k];
`ifdef AVALON_RAM_AGENT_ERR_EN
        resp_err = err[k];
`else
        resp_err = 1'b0;
`endif
        read[k]  = 1'b0;
        write[k] = 1'b0;
    endtask

    task automatic wr_word(input int k, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input string tag);
        logic [31:0] d;
        logic        v;
        int          lat;
        xfer(k, 1'b0, 1'b1, a, be, wd, d, v, lat);
        chk({tag, "_lat"}, lat, ws_of(k) + 1);
        chk({tag, "_rdv"}, {31'd0, v}, 32'd0);
        $display("write k=%0d addr=0x%08h be=%b data=0x%08h lat=%0d", k, a, be, wd, lat);
    endtask

    task automatic rd_word(input int k, input logic rd_and_wr, input logic [31:0] a,
                           input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic        v;
        int          lat;
        xfer(k, 1'b1, rd_and_wr, a, 4'hF, 32'h0, d, v, lat);
        chk({tag, "_lat"}, lat, ws_of(k) + 1);
        chk({tag, "_rdv"}, {31'd0, v}, 32'd1);
        chk({tag, "_data"}, d, exp);
        @(negedge clk);
        chk({tag, "_rdv_end"}, {31'd0, readdatavalid[k]}, 32'd0);
        $display("read  k=%0d addr=0x%08h data=0x%08h lat=%0d", k, a, d, lat);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            address[k] = '0; read[k] = 1'b0; write[k] = 1'b0;
            byteenable[k] = '0; host_to_agent[k] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_waitreq", {31'd0, waitrequest[0]}, 32'd1);
        chk("rst_rdv", {31'd0, readdatavalid[0]}, 32'd0);
        chk("rst_rdata", agent_to_host[0], 32'h0);

        // Basic write/read, WAIT_STATES=1
        wr_word(0, 32'h10, 4'hF, 32'hDEADBEEF, "wr10");
        rd_word(0, 1'b0, 32'h10, 32'hDEADBEEF, "rd10");

        // Lane writes
        wr_word(0, 32'h20, 4'hF, 32'h11223344, "wr20");
        wr_word(0, 32'h20, 4'b0001, 32'h000000AA, "wr20_b0");
        rd_word(0, 1'b0, 32'h20, 32'h112233AA, "rd20_b0");
        wr_word(0, 32'h20, 4'b0011, 32'h0000BBCC, "wr20_b01");
        rd_word(0, 1'b0, 32'h20, 32'h1122BBCC, "rd20_b01");

        // byteenable=0000 write leaves memory unchanged
        wr_word(0, 32'h20, 4'b0000, 32'hFFFFFFFF, "wr20_be0");
        rd_word(0, 1'b0, 32'h20, 32'h1122BBCC, "rd20_be0");

        // read+write together acts as a read, write data discarded
        rd_word(0, 1'b1, 32'h10, 32'hDEADBEEF, "rdwr10");
        rd_word(0, 1'b0, 32'h10, 32'hDEADBEEF, "rd10_again");

        // Latency sweep on WAIT_STATES=0 and 3
        wr_word(1, 32'h8, 4'hF, 32'hA5A5A5A5, "ws0_wr");
        rd_word(1, 1'b0, 32'h8, 32'hA5A5A5A5, "ws0_rd");
        wr_word(2, 32'h30, 4'hF, 32'h12345678, "ws3_wr30");
        rd_word(2, 1'b0, 32'h30, 32'h12345678, "ws3_rd30");

        // Abort a write to 0x30 during WAIT
        @(negedge clk);
        address[2] = 32'h30; byteenable[2] = 4'hF; host_to_agent[2] = 32'hFFFFFFFF;
        write[2] = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        write[2] = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (!waitrequest[2] || readdatavalid[2]) bad = 1'b1;
        end
        chk("abort_no_resp", {31'd0, bad}, 32'd0);
        $display("abort k=2 addr=0x00000030 response_seen=%0d", bad);
        rd_word(2, 1'b0, 32'h30, 32'h12345678, "abort_rd30");

        // Reset during WAIT of a write to 0x40
        wr_word(2, 32'h40, 4'hF, 32'hCAFEF00D, "wr40");
        @(negedge clk);
        address[2] = 32'h40; byteenable[2] = 4'hF; host_to_agent[2] = 32'h0;
        write[2] = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        write[2] = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rstw_waitreq", {31'd0, waitrequest[2]}, 32'd1);
        chk("rstw_rdv", {31'd0, readdatavalid[2]}, 32'd0);
        chk("rstw_rdata", agent_to_host[2], 32'h0);
        $display("reset during WAIT k=2 addr=0x00000040");
        rd_word(2, 1'b0, 32'h40, 32'hCAFEF00D, "rstw_rd40");

`ifndef AVALON_RAM_AGENT_ERR_EN
        // Address wrap modulo DEPTH*4
        wr_word(0, 32'h1004, 4'hF, 32'h00000055, "wrap_wr");
        rd_word(0, 1'b0, 32'h0004, 32'h00000055, "wrap_rd4");
        rd_word(0, 1'b0, 32'h0006, 32'h00000055, "wrap_rd6");
`else
        // Sticky error flag
        pulse_rst();
        chk("err_rst0", {31'd0, err[0]}, 32'd0);
        wr_word(0, 32'h0, 4'hF, 32'h01020304, "err_wr0");
        chk("err_legal", {31'd0, resp_err}, 32'd0);
        wr_word(0, 32'h2000, 4'hF, 32'hFFFFFFFF, "err_oor");
        chk("err_oor_resp", {31'd0, resp_err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("err_sticky", {31'd0, err[0]}, 32'd1);
        rd_word(0, 1'b0, 32'h0, 32'h01020304, "err_rd0");
        pulse_rst();
        chk("err_rst1", {31'd0, err[0]}, 32'd0);
        wr_word(0, 32'h0, 4'b0100, 32'h00FF0000, "err_be");
        chk("err_be_resp", {31'd0, resp_err}, 32'd1);
        rd_word(0, 1'b0, 32'h0, 32'h01020304, "err_be_rd0");
        pulse_rst();
        chk("err_rst2", {31'd0, err[0]}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/avalon_ram_agent.md
Name: avalon_ram_agent

Overview:
- Avalon-MM agent (responder) with a word-organised RAM behind it, for use as data/instruction memory on the core's AvalonMmRw bus.
- Serves the host side of the memory unit: single outstanding transfer, programmable wait states, byte-lane writes.
- Holds waitrequest high until the response is ready, then drops waitrequest and asserts readdatavalid in the same cycle, matching hosts that complete on readdatavalid && !waitrequest.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- WAIT_STATES, 1, extra stall cycles inserted before the response; 0 allowed.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high; one clock; all state updates on posedge clk.
- port  AvalonMmRw.Agent  -  bus interface with these members:
  - address (in, 32): byte address.
  - read, write (in, 1): request strobes.
  - byteenable (in, 4): active byte lanes.
  - host_to_agent (in, 32): write data.
  - agent_to_host (out, 32): read data.
  - waitrequest (out, 1): stall.
  - readdatavalid (out, 1): read data valid.

Behaviour:
- Storage: DEPTH x 32-bit array. Word index = address[$clog2(DEPTH)+1:2]. address[1:0] is ignored; byteenable selects lanes of that word directly. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- States: IDLE, WAIT, RESP. Counter cnt has width $clog2(WAIT_STATES+1).
- IDLE:
  - If read or write is high, latch op, word index, byteenable and write data.
  - Go to WAIT with cnt=WAIT_STATES-1 when WAIT_STATES>0; otherwise go to RESP.
- WAIT:
  - Decrement cnt; at cnt==0, go to RESP.
  - If the host deasserts both read and write, abort to IDLE. No commit, no readdatavalid.
- RESP: lasts exactly one cycle, then IDLE.
  - Write: commit latched data to each lane with byteenable[i]=1 (lane i = bits 8i+7:8i). Other lanes unchanged.
  - Read: agent_to_host holds the full 32-bit word, which was loaded on entry to RESP. No masking or extension; the host does that.
- Outputs:
  - waitrequest = (state != RESP).
  - readdatavalid = (state == RESP && latched op == read).
  - agent_to_host holds the last read word outside RESP.
- Latency: request seen in IDLE at cycle t, response cycle at t+WAIT_STATES+1. Minimum one stall cycle.
- Back-to-back transfers: a request present in the cycle after RESP is accepted as a new transfer. One transfer minimum per WAIT_STATES+2 cycles.
- read and write both high in IDLE: treated as a read; write data is discarded.
- byteenable=0000 on a write: completes normally, memory unchanged.
- Reset values:
  - state=IDLE, waitrequest=1, readdatavalid=0, agent_to_host=0.
  - Memory contents are not cleared.
- Reset mid-operation (WAIT or RESP): returns to IDLE next cycle. A pending write is not committed.

Optional Feature:
- Macro: AVALON_RAM_AGENT_ERR_EN.
- Defined: adds port err (output, 1). err is a sticky flag, cleared only by rst. It sets in the RESP cycle of any transfer with:
  - address >= DEPTH*4 (out of range); or
  - byteenable not in {0001, 0011, 1111}; or
  - read and write both high at accept.
- Defined: an erroring write is not committed. An erroring read still returns the wrapped word.
- Not defined: no err port; wrap-around and all byteenable values behave as described above.

Test Plan:
- After rst: waitrequest=1, readdatavalid=0, agent_to_host=0. With WAIT_STATES=1, write 0xDEADBEEF, be=1111, to address 0x10; then read 0x10 -> readdatavalid pulses for one cycle with waitrequest=0, agent_to_host=0xDEADBEEF, 2 cycles after read rises.
- Lane writes: word 0x20 holds 0x11223344; write data 0x000000AA, be=0001 -> reads 0x112233AA. Then write 0x0000BBCC, be=0011 -> reads 0x1122BBCC.
- Latency sweep: with WAIT_STATES in {0,1,3}, the response cycle is exactly 1, 2, 4 cycles after request; waitrequest is high in every cycle before it.
- Abort: a write to 0x30 is dropped during WAIT (WAIT_STATES=3) -> no response pulse and word 0x30 unchanged. Reset asserted during WAIT of a write to 0x40 -> word 0x40 unchanged and state IDLE.
- Wrap: with DEPTH=1024, write 0x55 to address 0x1004 -> a read of 0x0004 returns 0x55, and address 0x0006 returns the same word.
- AVALON_RAM_AGENT_ERR_EN defined: a write to 0x2000 with DEPTH=1024 -> err=1 in its RESP cycle and stays 1; word 0x0000 unchanged. A write with be=0100 -> err set, no commit. rst -> err=0.
